// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seven_seg_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } scan_state_e;

    // All-ones mask for the low n select bits; callers narrow it to their digit count.
    function automatic logic [MAX_DIGITS-1:0] sel_off(input int unsigned n);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared 7-segment decoder.
// Shadow contents only change at frame boundaries so a frame never shows mixed data.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned CLKS_PER_DIGIT = 2500,
    parameter int unsigned DEAD_CLKS      = 2
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst_L,
    input  logic                           i_EN,
    input  logic                           i_Load,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_Digits,
    input  logic [NUM_DIGITS-1:0]          i_DP_Mask,
    input  logic [NUM_DIGITS-1:0]          i_Blank_Mask,
    output logic [NIBBLE_W-1:0]            o_Binary_Num,
    output logic                           o_Dec_EN,
    output logic                           o_DP,
    output logic [NUM_DIGITS-1:0]          o_Digit_Sel,
    output logic                           o_Frame_Done
);

    localparam int unsigned CNT_MAX = (CLKS_PER_DIGIT > DEAD_CLKS) ? CLKS_PER_DIGIT : DEAD_CLKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned DIG_W   = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned SH_W    = DIG_W + 2 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      DRIVE_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0]      DEAD_LAST   = CNT_W'(DEAD_CLKS - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ALL_OFF = NUM_DIGITS'(sel_off(NUM_DIGITS));

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    // Packed as {blank, dp, digits}.
    logic [SH_W-1:0]         shadow_q, shadow_d;
    logic [SH_W-1:0]         pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [NIBBLE_W-1:0]     bin_q, bin_d;
    logic                    dec_en_q, dec_en_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    frame_done_q, frame_done_d;

    logic [SH_W-1:0]         load_data;
    logic                    frame_end;
    logic                    boundary;
    logic [DIG_W-1:0]        digits_nx;
    logic [NUM_DIGITS-1:0]   dp_nx;
    logic [NUM_DIGITS-1:0]   blank_nx;

    assign load_data = {i_Blank_Mask, i_DP_Mask, i_Digits};
    assign frame_end = (state_q == StDrive) && (idx_q == IDX_LAST) && (cnt_q == DRIVE_LAST);
    assign boundary  = i_EN && ((state_q == StIdle) || frame_end);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        // Loads on a boundary bypass pending; pending always mirrors the latest load.
        if (boundary) begin
            if (i_Load) begin
                pend_d   = load_data;
                shadow_d = load_data;
            end else if (pend_vld_q) begin
                shadow_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end else if (i_Load) begin
            pend_d     = load_data;
            pend_vld_d = 1'b1;
        end

        if (!i_EN) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                StBlank: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = StDrive;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StDrive: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next state so the registered copies line up with state_q.
    always_comb begin
        digits_nx    = shadow_d[DIG_W-1:0];
        dp_nx        = shadow_d[DIG_W+NUM_DIGITS-1:DIG_W];
        blank_nx     = shadow_d[SH_W-1:DIG_W+NUM_DIGITS];
        bin_d        = '0;
        dp_d         = 1'b0;
        dec_en_d     = 1'b0;
        sel_d        = SEL_ALL_OFF;
        frame_done_d = 1'b0;
        if (state_d != StIdle) begin
            bin_d    = digits_nx[NIBBLE_W*int'(idx_d) +: NIBBLE_W];
            dp_d     = dp_nx[idx_d];
            dec_en_d = ~blank_nx[idx_d];
            if ((state_d == StDrive) && !blank_nx[idx_d]) begin
                sel_d = SEL_ALL_OFF & ~(NUM_DIGITS'(1) << idx_d);
            end
            frame_done_d = (state_d == StDrive) && (idx_d == IDX_LAST) && (cnt_d == DRIVE_LAST);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            bin_q        <= '0;
            dec_en_q     <= 1'b0;
            dp_q         <= 1'b0;
            sel_q        <= SEL_ALL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            bin_q        <= bin_d;
            dec_en_q     <= dec_en_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_Binary_Num = bin_q;
    assign o_Dec_EN     = dec_en_q;
    assign o_DP         = dp_q;
    assign o_Digit_Sel  = sel_q;
    assign o_Frame_Done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl against a slot-arithmetic reference model.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int CPD   = 8;
    localparam int DEAD  = 2;
    localparam int SLOT  = CPD + DEAD;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   digits = '0;
    logic [3:0]    dp_mask = '0;
    logic [3:0]    blank_mask = '0;
    logic [3:0]    o_bin;
    logic          o_en;
    logic          o_dp;
    logic [3:0]    o_sel;
    logic          o_fd;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS    (ND),
        .CLKS_PER_DIGIT(CPD),
        .DEAD_CLKS     (DEAD)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_EN        (en),
        .i_Load      (load),
        .i_Digits    (digits),
        .i_DP_Mask   (dp_mask),
        .i_Blank_Mask(blank_mask),
        .o_Binary_Num(o_bin),
        .o_Dec_EN    (o_en),
        .o_DP        (o_dp),
        .o_Digit_Sel (o_sel),
        .o_Frame_Done(o_fd)
    );

    always #5 clk = ~clk;

    // Reference model: cycles counted from enable; frame contents latch at each frame start.
    bit          running = 0;
    int          k = 0;
    logic [23:0] shown = '0;
    logic [23:0] latest = '0;
    int          exp_d, exp_w;
    logic [3:0]  exp_sel, exp_bin;
    logic        exp_dp, exp_en, exp_fd;

    task automatic tick();
        logic [23:0] in_data;
        int slot;
        @(posedge clk);
        in_data = {blank_mask, dp_mask, digits};
        if (!rst_l) begin
            running = 0; k = 0; shown = '0; latest = '0;
        end else if (!en) begin
            running = 0;
            if (load) latest = in_data;
        end else if (!running) begin
            running = 1; k = 0;
            if (load) latest = in_data;
            shown = latest;
        end else begin
            if (load) latest = in_data;
            k++;
            if (k % FRAME == 0) shown = latest;
        end
        #1;
        if (!running) begin
            exp_d = -1; exp_w = -1;
            exp_sel = 4'hF; exp_bin = 4'h0; exp_dp = 0; exp_en = 0; exp_fd = 0;
        end else begin
            slot    = k % FRAME;
            exp_d   = slot / SLOT;
            exp_w   = slot % SLOT;
            exp_bin = shown[4*exp_d +: 4];
            exp_dp  = shown[16+exp_d];
            exp_en  = !shown[20+exp_d];
            exp_sel = (exp_w >= DEAD && !shown[20+exp_d]) ? ~(4'b0001 << exp_d) : 4'hF;
            exp_fd  = (slot == FRAME - 1);
        end
    endtask

    task automatic run_until(input int d, input int w, input string nm);
        for (int i = 0; i < 2 * FRAME && !(exp_d == d && exp_w == w); i++) tick();
        checks++;
        if (!(exp_d == d && exp_w == w)) begin
            errors++;
            $display("FAIL %s_wait: got digit=%0d slot=%0d, want digit=%0d slot=%0d",
                     nm, exp_d, exp_w, d, w);
        end
    endtask

    // Structural invariants, checked every cycle.
    logic [3:0] prev_bin = '0;
    always @(negedge clk) begin
        if (rst_l) begin
            checks++;
            if ($countones(~o_sel) > 1) begin
                errors++;
                $display("FAIL one_hot_sel: got sel=%b, want at most one low bit", o_sel);
            end
            if (o_sel != 4'hF) begin
                checks++;
                if (o_bin !== prev_bin) begin
                    errors++;
                    $display("FAIL bin_stable: got bin=%h while selected, want %h", o_bin, prev_bin);
                end
            end
        end
        prev_bin = o_bin;
    end

    task automatic test_reset();
        rst_l = 0; en = 1; load = 1;
        digits = 16'($urandom); dp_mask = 4'($urandom); blank_mask = 4'($urandom);
        tick(); tick();
        load = 0;
        checks += 5;
        if (o_sel !== 4'hF) begin errors++; $display("FAIL reset_sel: got %b, want 1111", o_sel); end
        if (o_bin !== 4'h0) begin errors++; $display("FAIL reset_bin: got %h, want 0", o_bin); end
        if (o_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b, want 0", o_en); end
        if (o_dp !== 1'b0) begin errors++; $display("FAIL reset_dp: got %b, want 0", o_dp); end
        if (o_fd !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b, want 0", o_fd); end
    endtask

    task automatic test_scan();
        int last_fd = -1;
        rst_l = 1; en = 1; load = 1;
        digits = 16'h4321; dp_mask = '0; blank_mask = '0;
        for (int c = 0; c < 2 * FRAME + 5; c++) begin
            tick();
            load = 0;
            checks++;
            if ({o_sel, o_bin, o_dp, o_en, o_fd} !== {exp_sel, exp_bin, exp_dp, exp_en, exp_fd}) begin
                errors++;
                $display("FAIL scan c=%0d: got sel=%b bin=%h dp=%b en=%b fd=%b, want %b %h %b %b %b",
                         c, o_sel, o_bin, o_dp, o_en, o_fd, exp_sel, exp_bin, exp_dp, exp_en, exp_fd);
            end
            if (o_fd === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (c - last_fd != FRAME) begin
                        errors++;
                        $display("FAIL frame_period: got %0d, want %0d", c - last_fd, FRAME);
                    end
                end
                last_fd = c;
            end
        end
    endtask

    task automatic test_midframe_load();
        run_until(1, 5, "midload");
        load = 1; digits = 16'h8765;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            load = 0;
            checks++;
            if ({o_sel, o_bin, o_fd} !== {exp_sel, exp_bin, exp_fd}) begin
                errors++;
                $display("FAIL midload c=%0d: got sel=%b bin=%h fd=%b, want %b %h %b",
                         c, o_sel, o_bin, o_fd, exp_sel, exp_bin, exp_fd);
            end
        end
    endtask

    task automatic test_boundary_load();
        run_until(3, SLOT - 1, "bndload");
        checks++;
        if (o_fd !== 1'b1) begin errors++; $display("FAIL bnd_fd: got %b, want 1", o_fd); end
        load = 1; digits = 16'h00F0;
        tick();
        load = 0;
        checks++;
        if (o_bin !== 4'h0) begin errors++; $display("FAIL bnd_digit0: got %h, want 0", o_bin); end
        for (int c = 0; c < SLOT; c++) tick();
        checks++;
        if (o_bin !== 4'hF) begin errors++; $display("FAIL bnd_digit1: got %h, want F", o_bin); end
    endtask

    task automatic test_masks();
        load = 1; digits = 16'($urandom); dp_mask = 4'b0001; blank_mask = 4'b0100;
        tick();
        load = 0;
        run_until(0, 0, "masks");
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            checks++;
            if ({o_sel, o_bin, o_dp, o_en, o_fd} !== {exp_sel, exp_bin, exp_dp, exp_en, exp_fd}) begin
                errors++;
                $display("FAIL masks c=%0d: got sel=%b bin=%h dp=%b en=%b fd=%b, want %b %h %b %b %b",
                         c, o_sel, o_bin, o_dp, o_en, o_fd, exp_sel, exp_bin, exp_dp, exp_en, exp_fd);
            end
            if (exp_d == 2) begin
                checks++;
                if (o_sel[2] !== 1'b1 || o_en !== 1'b0) begin
                    errors++;
                    $display("FAIL blank_digit2: got sel=%b en=%b, want sel[2]=1 en=0", o_sel, o_en);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        run_until(2, 5, "endrop");
        en = 0;
        tick();
        checks += 2;
        if (o_sel !== 4'hF) begin errors++; $display("FAIL endrop_sel: got %b, want 1111", o_sel); end
        if (o_en !== 1'b0) begin errors++; $display("FAIL endrop_en: got %b, want 0", o_en); end
        tick();
        en = 1;
        for (int c = 0; c < DEAD + 1; c++) begin
            tick();
            checks++;
            if (o_sel !== ((c < DEAD) ? 4'hF : 4'hE)) begin
                errors++;
                $display("FAIL reenable c=%0d: got sel=%b, want %b", c, o_sel,
                         (c < DEAD) ? 4'hF : 4'hE);
            end
        end
    endtask

    task automatic test_reset_midframe();
        run_until(1, 6, "rstmid");
        rst_l = 0; load = 1; digits = 16'hABCD; dp_mask = 4'hF; blank_mask = 4'h0;
        tick();
        load = 0;
        checks++;
        if ({o_sel, o_bin, o_dp, o_en, o_fd} !== {4'hF, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid: got sel=%b bin=%h dp=%b en=%b fd=%b, want 1111 0 0 0 0",
                     o_sel, o_bin, o_dp, o_en, o_fd);
        end
        rst_l = 1;
        for (int c = 0; c < FRAME; c++) begin
            tick();
            checks++;
            if ({o_sel, o_bin, o_dp} !== {exp_sel, 4'h0, 1'b0}) begin
                errors++;
                $display("FAIL rstmid_zero c=%0d: got sel=%b bin=%h dp=%b, want %b 0 0",
                         c, o_sel, o_bin, o_dp, exp_sel);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst_l = ($urandom_range(0, 399) != 0);
            en    = ($urandom_range(0, 149) != 0);
            load  = ($urandom_range(0, 24) == 0);
            digits = 16'($urandom); dp_mask = 4'($urandom); blank_mask = 4'($urandom);
            tick();
            checks++;
            if ({o_sel, o_bin, o_dp, o_en, o_fd} !== {exp_sel, exp_bin, exp_dp, exp_en, exp_fd}) begin
                errors++;
                $display("FAIL random c=%0d: got sel=%b bin=%h dp=%b en=%b fd=%b, want %b %h %b %b %b",
                         c, o_sel, o_bin, o_dp, o_en, o_fd, exp_sel, exp_bin, exp_dp, exp_en, exp_fd);
            end
        end
        rst_l = 1; en = 1; load = 0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_boundary_load();
        test_masks();
        test_enable_drop();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scheduler that shares one Binary_To_7Segment decoder across NUM_DIGITS common-anode digits. Holds a shadow copy of all digit nibbles and steps through the digits in turn. For each digit it presents the nibble and decoder enable, then drives the matching active-low digit select. The parent instantiates this block and the decoder side by side, and ANDs decoder segment outputs with nothing else.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
CLKS_PER_DIGIT, 2500, clocks each digit select is held active (>=1)
DEAD_CLKS, 2, blanking clocks between digits; must be >=2 to cover decoder register latency

Ports:
i_Clk  input  1  system clock
i_Rst_L  input  1  synchronous active-low reset
i_EN  input  1  scan enable; low forces all digits off
i_Load  input  1  one-cycle strobe: capture i_Digits/i_DP_Mask/i_Blank_Mask
i_Digits  input  4*NUM_DIGITS  packed nibbles, digit 0 in [3:0]
i_DP_Mask  input  NUM_DIGITS  1 = light decimal point on that digit
i_Blank_Mask  input  NUM_DIGITS  1 = digit stays dark (select never asserted)
o_Binary_Num  output  4  nibble to decoder i_Binary_Num
o_Dec_EN  output  1  to decoder i_EN
o_DP  output  1  decimal point for current digit
o_Digit_Sel  output  NUM_DIGITS  active-low one-hot digit select; all-ones = off
o_Frame_Done  output  1  one-cycle pulse at end of last digit's drive window

Behaviour:
- Interface: one clock i_Clk; reset i_Rst_L is synchronous, active-low. All outputs registered.
- Reset (i_Rst_L=0 at edge):
  - State IDLE, digit index 0, counter 0, pending flag 0.
  - Shadow and pending registers 0.
  - o_Digit_Sel all 1s; o_Binary_Num 0; o_Dec_EN 0; o_DP 0; o_Frame_Done 0.
- States IDLE, BLANK, DRIVE; 2-bit encoding from package.
- IDLE: all selects off, o_Dec_EN 0.
  - i_EN=1 -> BLANK, index 0, counter 0.
  - Pending contents (or same-cycle i_Load data) copied to shadow.
- BLANK: o_Digit_Sel all 1s.
  - o_Binary_Num = shadow nibble[index]; o_DP = shadow DP[index].
  - o_Dec_EN = ~shadow blank[index].
  - After DEAD_CLKS cycles -> DRIVE, counter cleared.
- DRIVE: o_Digit_Sel[index]=0 unless blanked; nibble, DP and enable held.
  - After CLKS_PER_DIGIT cycles -> BLANK.
  - If index<NUM_DIGITS-1: index+1.
  - Otherwise index 0, o_Frame_Done=1 for exactly one cycle, pending -> shadow if pending flag set, flag cleared.
- Frame period exactly NUM_DIGITS*(DEAD_CLKS+CLKS_PER_DIGIT) clocks.
- Never more than one select low. A select never goes low in the same cycle the nibble changes.
- i_Load: captures inputs into pending and sets flag; the displayed value never changes mid-frame (no tearing).
  - i_Load on the frame-boundary cycle writes incoming data directly to shadow.
  - Back-to-back loads within a frame: last one wins.
- i_EN falling in any state: next cycle IDLE, all selects off, o_Dec_EN 0, index reset. Pending data is retained.
- Counter width $clog2(max(CLKS_PER_DIGIT,DEAD_CLKS)+1); terminal compare is == (count-1). No wrap past terminal.
- Reset mid-frame overrides everything, including a simultaneous i_Load or i_EN.

Decomposition:
- seven_seg_pkg: state typedef (IDLE/BLANK/DRIVE), NIBBLE_W=4 constant, SEL_OFF helper function returning all-ones of width N.
- No sub-module inside: counter and FSM inline. The decoder is instantiated by the parent, not within this block.

Test Plan:
(Sim parameters: NUM_DIGITS=4, CLKS_PER_DIGIT=8, DEAD_CLKS=2.)
- Reset, i_EN=1, load digits 0x4321:
  - Sel sequence 1110,1101,1011,0111 each low 8 clks with 2 clks all-1s between.
  - o_Binary_Num 1,2,3,4.
  - o_Frame_Done pulses every 40 clks.
- i_Load of 0x8765 mid-digit-1: current frame still shows 1,2,3,4; next frame shows 5,6,7,8.
- i_Load asserted on the o_Frame_Done cycle with 0x00F0: the immediately following digit 0 shows 0; digit 1 shows F.
- i_Blank_Mask=0100, i_DP_Mask=0001:
  - Digit 2 select never goes low; o_Dec_EN 0 during its slots.
  - o_DP=1 only during digit 0 slots.
  - Frame still 40 clks.
- Drop i_EN during DRIVE of digit 2: next clk o_Digit_Sel=1111, o_Dec_EN=0. Re-enable: scan restarts at digit 0 after 2 blank clks.
- Assert i_Rst_L=0 for one clk mid-DRIVE together with i_Load: all outputs at reset values next clk; shadow reads 0 after re-enable.
- Checker in all tests: at most one select bit low at any cycle; o_Binary_Num stable whenever any select bit is low.
